// File: rtl/load_store_unit.sv
// Load/store front end for a 64-bit word-addressed memory: sub-word loads with extension, RMW stores.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned requests answer with resp_err instead of aligning down.
module load_store_unit #(
    parameter int WORD_SIZE      = 64,
    parameter int DATA_ADDR_SIZE = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic                      req_signed,
    input  logic [DATA_ADDR_SIZE+2:0] req_addr,
    input  logic [WORD_SIZE-1:0]      req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [WORD_SIZE-1:0]      resp_rdata,
    output logic                      resp_err,
    output logic [DATA_ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]      mem_wdata,
    output logic                      mem_write,
    output logic                      mem_en,
    input  logic [WORD_SIZE-1:0]      mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_MRG, S_WR, S_RESP} state_t;

    state_t                    state_q, state_d;
    logic [DATA_ADDR_SIZE+2:0] addr_q;
    logic [1:0]                size_q;
    logic                      signed_q, write_q, err_q;
    logic [WORD_SIZE-1:0]      wdata_q, merged_q, rdata_q;

    logic [2:0]                low_mask;
    logic                      trap;
    logic [DATA_ADDR_SIZE+2:0] addr_in;

    always_comb begin
        case (req_size)
            2'b00:   low_mask = 3'b000;
            2'b01:   low_mask = 3'b001;
            2'b10:   low_mask = 3'b011;
            default: low_mask = 3'b111;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap    = |(req_addr[2:0] & low_mask);
    assign addr_in = req_addr;
`else
    assign trap    = 1'b0;
    assign addr_in = {req_addr[DATA_ADDR_SIZE+2:3], req_addr[2:0] & ~low_mask};
`endif

    // Field datapath, valid in MRG when mem_rdata carries the addressed word
    logic [WORD_SIZE-1:0] fmask, field, ld_ext, st_merge;
    logic [5:0]           sh;
    logic                 sbit;

    assign sh = {addr_q[2:0], 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   fmask = 64'h0000_0000_0000_00FF;
            2'b01:   fmask = 64'h0000_0000_0000_FFFF;
            2'b10:   fmask = 64'h0000_0000_FFFF_FFFF;
            default: fmask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign field = (mem_rdata >> sh) & fmask;

    always_comb begin
        case (size_q)
            2'b00:   sbit = field[7];
            2'b01:   sbit = field[15];
            2'b10:   sbit = field[31];
            default: sbit = field[63];
        endcase
    end

    assign ld_ext   = field | ((signed_q && sbit) ? ~fmask : '0);
    assign st_merge = (mem_rdata & ~(fmask << sh)) | ((wdata_q & fmask) << sh);

    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (trap)                                state_d = S_RESP;
                    else if (req_write && req_size == 2'b11) state_d = S_WR;
                    else                                     state_d = S_RD;
                end
            end
            S_RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q[DATA_ADDR_SIZE+2:3];
                state_d  = S_MRG;
            end
            S_MRG: state_d = write_q ? S_WR : S_RESP;
            S_WR: begin
                mem_en    = 1'b1;
                mem_write = 1'b1;
                mem_addr  = addr_q[DATA_ADDR_SIZE+2:3];
                mem_wdata = merged_q;
                state_d   = S_RESP;
            end
            S_RESP: if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (req_valid) begin
                    addr_q   <= addr_in;
                    size_q   <= req_size;
                    signed_q <= req_signed;
                    write_q  <= req_write;
                    wdata_q  <= req_wdata;
                    merged_q <= req_wdata;  // full-word stores skip the read
                    err_q    <= trap;
                    rdata_q  <= '0;
                end
                S_MRG: begin
                    if (write_q) merged_q <= st_merge;
                    else         rdata_q  <= ld_ext;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-level transaction model plus per-cycle output compare.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [10:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic        mem_write, mem_en;

    always #5 clk = ~clk;

    load_store_unit #(.WORD_SIZE(64), .DATA_ADDR_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_en(mem_en), .mem_rdata(mem_rdata)
    );

    // Memory with one-cycle read latency; ref_mem is the model's view of it
    logic [63:0] mem [256];
    logic [63:0] ref_mem [256];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 64'(i) * 64'h0001_0001_0001_0001;
        end else if (mem_en) begin
            if (mem_write) mem[mem_addr] <= mem_wdata;
            else           mem_rdata     <= mem[mem_addr];
        end
    end

    int          checks = 0;
    int          fails  = 0;
    logic        exp_wr_en = 1'b0, exp_err = 1'b0;
    logic [7:0]  exp_waddr = '0;
    logic [63:0] exp_wdata = '0, exp_rdata = '0;
    int          wr_seen = 0, en_seen = 0;
    logic [63:0] last_wdata = '0, last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Per-cycle compare of memory writes and responses against the model
    always @(negedge clk) begin
        if (mem_en) en_seen++;
        if (mem_en && mem_write) begin
            wr_seen++;
            last_wdata = mem_wdata;
            chk("wr_expected", 64'(exp_wr_en), 64'd1);
            chk("wr_addr", 64'(mem_addr), 64'(exp_waddr));
            chk("wr_data", mem_wdata, exp_wdata);
        end
        if (!rst && resp_valid) begin
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_err", 64'(resp_err), 64'(exp_err));
        end
    end

    task automatic chk_reset_outs(input logic rdy);
        chk("rst_req_ready", 64'(req_ready), 64'(rdy));
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [10:0] addr, input logic [63:0] wd, input int hold);
        int          nb, lat, ens, k, off;
        logic        err;
        logic [10:0] ea;
        logic [63:0] w, held;
        nb  = 1 << sz;
        err = 1'b0;
        ea  = addr & ~11'(nb - 1);
`ifdef LSU_MISALIGN_TRAP_EN
        err = (ea != addr);
`endif
        off = int'(ea[2:0]);
        w   = ref_mem[ea[10:3]];
        if (err) begin
            exp_rdata = '0; exp_err = 1'b1; exp_wr_en = 1'b0; lat = 1; ens = 0;
        end else if (wr) begin
            for (int i = 0; i < nb; i++) w[(off + i) * 8 +: 8] = wd[i * 8 +: 8];
            ref_mem[ea[10:3]] = w;
            exp_wr_en = 1'b1; exp_waddr = ea[10:3]; exp_wdata = w;
            exp_rdata = '0; exp_err = 1'b0;
            lat = (sz == 2'b11) ? 2 : 4;
            ens = (sz == 2'b11) ? 1 : 2;
        end else begin
            exp_rdata = '0;
            for (int i = 0; i < nb; i++) exp_rdata[i * 8 +: 8] = w[(off + i) * 8 +: 8];
            if (sgn && exp_rdata[nb * 8 - 1])
                for (int i = nb; i < 8; i++) exp_rdata[i * 8 +: 8] = 8'hFF;
            exp_err = 1'b0; exp_wr_en = 1'b0; lat = 3; ens = 1;
        end
        wr_seen = 0;
        en_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0; req_wdata = '0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!resp_valid && k < 20);
        chk("resp_latency", 64'(k), 64'(lat));
        held = resp_rdata; last_rdata = resp_rdata; last_err = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_resp_valid", 64'(resp_valid), 64'd1);
            chk("bp_rdata_stable", resp_rdata, held);
            chk("bp_mem_en", 64'(mem_en), 64'd0);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        chk("wr_count", 64'(wr_seen), 64'(exp_wr_en));
        chk("en_count", 64'(en_seen), 64'(ens));
        exp_wr_en = 1'b0;
    endtask

    // Byte store of 0x55 to 0x19, reset asserted while in WR (in_wr=1) or in RD (in_wr=0)
    task automatic rst_mid(input logic in_wr);
        logic [63:0] old, merged;
        old    = ref_mem[3];
        merged = old;
        merged[15:8] = 8'h55;
        exp_wr_en = in_wr; exp_waddr = 8'd3; exp_wdata = merged;
        wr_seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 11'h019; req_wdata = 64'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (in_wr) begin
            @(posedge clk);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outs(1'b0);
        rst = 1'b0;
        #1 chk("rst_ready_after", 64'(req_ready), 64'd1);
        chk("rst_mid_wr_count", 64'(wr_seen), 64'(in_wr));
        chk("rst_mid_mem", mem[3], in_wr ? merged : old);
        if (in_wr) ref_mem[3] = merged;
        exp_wr_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 64'(i) * 64'h0001_0001_0001_0001;
        preload = 1'b1; rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outs(1'b0);
        preload = 1'b0; rst = 1'b0;
        #1 chk_reset_outs(1'b1);

        do_req(1'b1, 2'b11, 1'b0, 11'h010, 64'h0123_4567_89AB_CDEF, 0);
        chk("lit_st_dword", last_wdata, 64'h0123_4567_89AB_CDEF);
        do_req(1'b0, 2'b11, 1'b0, 11'h010, '0, 0);
        chk("lit_ld_dword", last_rdata, 64'h0123_4567_89AB_CDEF);
        do_req(1'b1, 2'b00, 1'b0, 11'h013, 64'hFFFF_FFFF_FFFF_FFAA, 0);
        chk("lit_rmw_byte", last_wdata, 64'h0123_4567_AAAB_CDEF);
        do_req(1'b0, 2'b11, 1'b0, 11'h010, '0, 0);
        chk("lit_ld_after_rmw", last_rdata, 64'h0123_4567_AAAB_CDEF);
        do_req(1'b0, 2'b00, 1'b1, 11'h013, '0, 0);
        chk("lit_ld_byte_s", last_rdata, 64'hFFFF_FFFF_FFFF_FFAA);
        do_req(1'b0, 2'b01, 1'b0, 11'h014, '0, 0);
        chk("lit_ld_half_u", last_rdata, 64'h0000_0000_0000_4567);
        do_req(1'b0, 2'b10, 1'b1, 11'h010, '0, 0);
        chk("lit_ld_word_s", last_rdata, 64'hFFFF_FFFF_AAAB_CDEF);

        do_req(1'b0, 2'b10, 1'b0, 11'h012, '0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lit_misalign_rdata", last_rdata, 64'd0);
        chk("lit_misalign_err", 64'(last_err), 64'd1);
`else
        chk("lit_misalign_rdata", last_rdata, 64'h0000_0000_AAAB_CDEF);
        chk("lit_misalign_err", 64'(last_err), 64'd0);
`endif

        do_req(1'b1, 2'b01, 1'b0, 11'h01E, 64'h1234_BEEF, 0);
        chk("lit_rmw_half", last_wdata, 64'hBEEF_0003_0003_0003);
        do_req(1'b1, 2'b10, 1'b0, 11'h024, 64'hCAFE_F00D, 0);
        chk("lit_rmw_word", last_wdata, 64'hCAFE_F00D_0004_0004);
        do_req(1'b0, 2'b10, 1'b0, 11'h024, '0, 0);
        chk("lit_ld_word_u", last_rdata, 64'h0000_0000_CAFE_F00D);

        do_req(1'b1, 2'b11, 1'b0, 11'h010, 64'h8000_0000_0000_0000, 0);
        do_req(1'b0, 2'b01, 1'b1, 11'h016, '0, 0);
        chk("lit_sext_half", last_rdata, 64'hFFFF_FFFF_FFFF_8000);
        do_req(1'b0, 2'b01, 1'b0, 11'h016, '0, 5);
        chk("lit_zext_half", last_rdata, 64'h0000_0000_0000_8000);
        do_req(1'b0, 2'b00, 1'b1, 11'h017, '0, 2);

        rst_mid(1'b1);
        chk("lit_rst_wr_mem", mem[3], 64'hBEEF_0003_0003_5503);
        do_req(1'b0, 2'b11, 1'b0, 11'h018, '0, 0);
        rst_mid(1'b0);
        do_req(1'b0, 2'b11, 1'b0, 11'h018, '0, 0);
        chk("lit_rst_rd_mem", last_rdata, 64'hBEEF_0003_0003_5503);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
